// File: rtl/instr_fetch_buf.sv
// Instruction fetch queue: issue -> push one cycle later -> decode the next cycle; backpressure via pc_hold when credit runs out.
// Optional macro IFB_BYPASS_EN presents a response arriving into an empty queue to decode in its arrival cycle.
module instr_fetch_buf #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pc_addr,
  output logic       pc_hold,
  input  logic       flush,
  output logic       imem_en,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  output logic       id_valid,
  input  logic       id_ready,
  output logic [7:0] id_instr,
  output logic [7:0] id_pc
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_fetch_buf: DEPTH must be a power of two in 2..16");
  end

  typedef enum logic {IDLE, FETCH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [AW-1:0]   head, tail;
  logic            inflight;
  logic [7:0]      req_addr;
  logic [15:0]     mem [DEPTH];

  logic            empty;
  logic [CW:0]     used;
  logic            byp;
  logic            issue, push, pop;

  assign empty = (count == '0);
  // Credit comes from registered occupancy only; a same-cycle pop never frees a slot.
  assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};

`ifdef IFB_BYPASS_EN
  assign byp = inflight && empty && !flush;
`else
  assign byp = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    imem_en   = 1'b0;
    imem_addr = 8'h00;
    pc_hold   = 1'b1;
    id_valid  = 1'b0;
    id_instr  = 8'h00;
    id_pc     = 8'h00;
    pop       = 1'b0;
    push      = 1'b0;

    if (state == IDLE) begin
      state_nxt = FETCH;
    end

    issue     = (state == FETCH) && !flush && (used < DEPTH_W);
    imem_en   = issue;
    imem_addr = issue ? pc_addr : 8'h00;
    // A flush releases the PC so it can load the branch target.
    pc_hold   = !(issue || ((state == FETCH) && flush));

    id_valid = !flush && (!empty || byp);
    if (!empty) begin
      {id_instr, id_pc} = mem[head];
    end else if (byp) begin
      {id_instr, id_pc} = {imem_rdata, req_addr};
    end

    pop  = id_valid && id_ready && !empty;
    push = inflight && !flush && !(byp && id_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
      req_addr <= 8'h00;
    end else if (flush) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        req_addr <= pc_addr;
      end
      if (push) begin
        tail <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= {imem_rdata, req_addr};
    end
  end

endmodule

// File: tb/tb_instr_fetch_buf.sv
// Two instances (DEPTH 4 and 2) checked every cycle against a queue-based transaction model.
module tb_instr_fetch_buf;
`ifdef IFB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       id_ready;
  logic [7:0] pc_addr    [2];
  logic [7:0] imem_rdata [2];
  logic       pc_hold    [2];
  logic       imem_en    [2];
  logic [7:0] imem_addr  [2];
  logic       id_valid   [2];
  logic [7:0] id_instr   [2];
  logic [7:0] id_pc      [2];

  always #5 clk = ~clk;

  instr_fetch_buf #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr[0]), .pc_hold(pc_hold[0]), .flush(flush),
    .imem_en(imem_en[0]), .imem_addr(imem_addr[0]), .imem_rdata(imem_rdata[0]),
    .id_valid(id_valid[0]), .id_ready(id_ready), .id_instr(id_instr[0]), .id_pc(id_pc[0]));

  instr_fetch_buf #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr[1]), .pc_hold(pc_hold[1]), .flush(flush),
    .imem_en(imem_en[1]), .imem_addr(imem_addr[1]), .imem_rdata(imem_rdata[1]),
    .id_valid(id_valid[1]), .id_ready(id_ready), .id_instr(id_instr[1]), .id_pc(id_pc[1]));

  // Reference model: per-instance FIFO of {instr, pc}, one outstanding read, a PC.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          dep [2] = '{4, 2};
  bit          started [2];
  bit          infl [2];
  logic [7:0]  iaddr [2];
  logic [7:0]  pc [2];
  int          n_issue [2];
  int          first_valid [2];
  int          since_rel;
  int          checks = 0;
  int          errors = 0;

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [15:0] qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int i, input logic [15:0] v);
    if (i == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic qclear(input int i);
    if (i == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
    end
  endtask

  task automatic cycle(input logic rdy, input logic fl, input logic [7:0] tgt);
    bit          iss  [2];
    bit          vld  [2];
    bit          bypd [2];
    logic [15:0] e;
    id_ready = rdy;
    flush    = fl;
    for (int i = 0; i < 2; i++) begin
      pc_addr[i]    = pc[i];
      imem_rdata[i] = infl[i] ? (iaddr[i] ^ 8'hA5) : 8'($urandom);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      iss[i]  = started[i] && !fl && ((qsize(i) + int'(infl[i])) < dep[i]);
      bypd[i] = BYP && (qsize(i) == 0) && infl[i] && !fl;
      vld[i]  = !fl && ((qsize(i) > 0) || bypd[i]);
      e = (qsize(i) > 0) ? qfront(i) : (bypd[i] ? {iaddr[i] ^ 8'hA5, iaddr[i]} : 16'h0000);
      chk("imem_en", i, 8'(imem_en[i]), 8'(iss[i]));
      chk("imem_addr", i, imem_addr[i], iss[i] ? pc[i] : 8'h00);
      chk("pc_hold", i, 8'(pc_hold[i]), (started[i] && fl) ? 8'h00 : 8'(!iss[i]));
      chk("id_valid", i, 8'(id_valid[i]), 8'(vld[i]));
      if (!fl) begin
        chk("id_instr", i, id_instr[i], e[15:8]);
        chk("id_pc", i, id_pc[i], e[7:0]);
      end
      if (imem_en[i]) n_issue[i]++;
      if (rst_n && id_valid[i] && first_valid[i] < 0) first_valid[i] = since_rel;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        qclear(i);
        infl[i]    = 1'b0;
        started[i] = 1'b0;
      end else if (fl) begin
        qclear(i);
        infl[i]    = 1'b0;
        pc[i]      = tgt;
        started[i] = 1'b1;
      end else begin
        if (vld[i] && rdy && qsize(i) > 0) qpop(i);
        if (infl[i] && !(bypd[i] && rdy)) qpush(i, {iaddr[i] ^ 8'hA5, iaddr[i]});
        infl[i]  = iss[i];
        iaddr[i] = pc[i];
        if (iss[i]) pc[i] = pc[i] + 8'h01;
        started[i] = 1'b1;
      end
    end
    since_rel++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs;
    for (int i = 0; i < 2; i++) begin
      chk("rst_imem_en", i, 8'(imem_en[i]), 8'h00);
      chk("rst_imem_addr", i, imem_addr[i], 8'h00);
      chk("rst_pc_hold", i, 8'(pc_hold[i]), 8'h01);
      chk("rst_id_valid", i, 8'(id_valid[i]), 8'h00);
      chk("rst_id_instr", i, id_instr[i], 8'h00);
      chk("rst_id_pc", i, id_pc[i], 8'h00);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    id_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pc[i] = 8'h00; iaddr[i] = 8'h00; infl[i] = 1'b0; started[i] = 1'b0;
      n_issue[i] = 0; first_valid[i] = -1;
      pc_addr[i] = 8'h00; imem_rdata[i] = 8'h00;
    end
    since_rel = 0;

    // Reset state
    #1;
    check_reset_outputs();
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);

    // Release: PC steps from 0x00, decode always ready
    rst_n = 1'b1;
    since_rel = 0;
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) chk("first_valid_cycle", i, 8'(first_valid[i]), BYP ? 8'd2 : 8'd3);

    // Flush to 0x40, then fill with decode stalled: exactly DEPTH issues
    cycle(1'b0, 1'b1, 8'h40);
    n_issue[0] = 0; n_issue[1] = 0;
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 8'h00);
    chk("fill_issues", 0, 8'(n_issue[0]), 8'd4);
    chk("fill_issues", 1, 8'(n_issue[1]), 8'd2);
    n_issue[0] = 0; n_issue[1] = 0;
    cycle(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 8'h00);
    chk("one_more_issue", 0, 8'(n_issue[0]), 8'd1);
    chk("one_more_issue", 1, 8'(n_issue[1]), 8'd1);

    // Flush while a fetch is in flight and entries are queued
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h80);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 8'h00);

    // Ready toggling 1,0,... for 64 cycles: exercises pointer wrap on DEPTH=2
    for (int k = 0; k < 64; k++) cycle(((k % 2) == 0), 1'b0, 8'h00);

    // Asynchronous reset pulse between edges
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      qclear(i); infl[i] = 1'b0; started[i] = 1'b0;
    end
    @(negedge clk);
    cycle(1'b1, 1'b0, 8'h00);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 8'h00);

    // Random ready and occasional flush to random targets
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
